// File: rtl/reg_target_uart_sniff.sv
// Passive target-IO UART sniffer on the OpenADC register bus.
// Received bytes are buffered in a FIFO for host readout.
module reg_target_uart_sniff #(
  parameter logic [5:0] ADDR_CFG  = 6'd56,
  parameter logic [5:0] ADDR_DATA = 6'd57,
  parameter int         FIFO_AW   = 6
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic [5:0]  reg_address,
  input  logic [15:0] reg_bytecnt,
  input  logic [7:0]  reg_datai,
  output logic [7:0]  reg_datao,
  input  logic [15:0] reg_size,
  input  logic        reg_read,
  input  logic        reg_write,
  input  logic        reg_addrvalid,
  input  logic [5:0]  reg_hypaddress,
  output logic [15:0] reg_hyplen,
  input  logic        rx_io1_i,
  input  logic        rx_io2_i,
  output logic        data_avail_o
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;

  logic        en;
  logic        src;
  logic        par_en;
  logic        par_odd;
  logic [15:0] div;
  logic        ovf;
  logic        ferr;
  logic        perr;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               full;
  logic               empty;
  logic               do_push;
  logic               do_pop;

  logic cfg_wr;
  logic clr;
  logic rd_strobe;
  logic rd_q;
  logic pop;

  logic line_sel;
  logic s1;
  logic s2;
  logic s_prev;
  logic fall;

  state_t      state;
  state_t      state_n;
  logic [15:0] cnt;
  logic [15:0] cnt_n;
  logic [2:0]  bitn;
  logic [2:0]  bitn_n;
  logic [7:0]  sh;
  logic [7:0]  sh_n;
  logic        armed;
  logic        armed_n;
  logic        push;
  logic        fe_set;
  logic        pe_set;

  logic [15:0] ediv;
  logic [15:0] half;
  logic        tick;
  logic [15:0] cnt_ext;
  logic [7:0]  cnt_byte;
  logic        unused;

  assign unused    = ^reg_size;
  assign cfg_wr    = reg_write && reg_addrvalid && (reg_address == ADDR_CFG);
  assign clr       = cfg_wr && (reg_bytecnt == 16'd0) && reg_datai[1];
  assign rd_strobe = reg_read && reg_addrvalid && (reg_address == ADDR_DATA);
  assign pop       = rd_strobe && !rd_q;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign line_sel = src ? rx_io2_i : rx_io1_i;
  assign fall     = s_prev && !s2;
  assign ediv     = (div < 16'd4) ? 16'd4 : div;
  assign half     = ediv >> 1;
  assign tick     = (cnt == 16'd0);

  assign cnt_ext  = 16'(count);
  assign cnt_byte = (cnt_ext > 16'd255) ? 8'hFF : cnt_ext[7:0];

  // Host-writable configuration bytes.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      en      <= 1'b0;
      src     <= 1'b0;
      par_en  <= 1'b0;
      par_odd <= 1'b0;
      div     <= 16'd833;
    end else if (cfg_wr) begin
      case (reg_bytecnt)
        16'd0: begin
          en      <= reg_datai[0];
          src     <= reg_datai[2];
          par_en  <= reg_datai[3];
          par_odd <= reg_datai[4];
        end
        16'd1: div[7:0]  <= reg_datai;
        16'd2: div[15:8] <= reg_datai;
        default: ;
      endcase
    end
  end

  // Read-strobe history for one pop per strobe.
  always_ff @(posedge clk) begin
    if (reset_i) rd_q <= 1'b0;
    else         rd_q <= rd_strobe;
  end

  // Two-flop synchroniser plus edge-detect history.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      s1     <= 1'b1;
      s2     <= 1'b1;
      s_prev <= 1'b1;
    end else begin
      s1     <= line_sel;
      s2     <= s1;
      s_prev <= s2;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state <= IDLE;
      cnt   <= 16'd0;
      bitn  <= 3'd0;
      sh    <= 8'd0;
      armed <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      bitn  <= bitn_n;
      sh    <= sh_n;
      armed <= armed_n;
    end
  end

  // Receiver next-state, bit sampling and push/error strobes.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bitn_n  = bitn;
    sh_n    = sh;
    armed_n = armed;
    push    = 1'b0;
    fe_set  = 1'b0;
    pe_set  = 1'b0;
    unique case (state)
      IDLE: begin
        if (s2) armed_n = 1'b1;
        if (en && armed && fall) begin
          state_n = START;
          cnt_n   = half;
          armed_n = 1'b0;
        end
      end
      START: begin
        if (!tick) begin
          cnt_n = cnt - 16'd1;
        end else if (!s2) begin
          state_n = DATA;
          cnt_n   = ediv - 16'd1;
          bitn_n  = 3'd0;
        end else begin
          state_n = IDLE;
        end
      end
      DATA: begin
        if (!tick) begin
          cnt_n = cnt - 16'd1;
        end else begin
          sh_n  = {s2, sh[7:1]};
          cnt_n = ediv - 16'd1;
          if (bitn == 3'd7) begin
            state_n = par_en ? PARITY : STOP;
          end else begin
            bitn_n = bitn + 3'd1;
          end
        end
      end
      PARITY: begin
        if (!tick) begin
          cnt_n = cnt - 16'd1;
        end else begin
          pe_set  = (s2 != ((^sh) ^ par_odd));
          state_n = STOP;
          cnt_n   = ediv - 16'd1;
        end
      end
      STOP: begin
        if (!tick) begin
          cnt_n = cnt - 16'd1;
        end else begin
          if (s2) push = 1'b1;
          else    fe_set = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (!en || clr) begin
      state_n = IDLE;
      push    = 1'b0;
      fe_set  = 1'b0;
      pe_set  = 1'b0;
    end
  end

  // FIFO pointers, count, sticky status and data-available flag.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      ovf          <= 1'b0;
      ferr         <= 1'b0;
      perr         <= 1'b0;
      data_avail_o <= 1'b0;
    end else begin
      data_avail_o <= !empty;
      if (clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        ovf    <= 1'b0;
        ferr   <= 1'b0;
        perr   <= 1'b0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + FIFO_AW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
        case ({do_push, do_pop})
          2'b10:   count <= count + (FIFO_AW+1)'(1);
          2'b01:   count <= count - (FIFO_AW+1)'(1);
          default: ;
        endcase
        if (push && !do_push) ovf <= 1'b1;
        if (fe_set) ferr <= 1'b1;
        if (pe_set) perr <= 1'b1;
      end
    end
  end

  // FIFO storage; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= sh;
  end

  // Read mux; zero when this block is not addressed.
  always_comb begin
    reg_datao = 8'h00;
    if (reg_address == ADDR_CFG) begin
      case (reg_bytecnt)
        16'd0: reg_datao = {3'b000, par_odd, par_en, src, 1'b0, en};
        16'd1: reg_datao = div[7:0];
        16'd2: reg_datao = div[15:8];
        16'd3: reg_datao = {3'b000, perr, ferr, ovf, full, empty};
        16'd4: reg_datao = cnt_byte;
        default: reg_datao = 8'h00;
      endcase
    end else if (reg_address == ADDR_DATA && !empty) begin
      reg_datao = mem[rd_ptr];
    end
  end

  // Register length answer for the hypothetical address.
  always_comb begin
    reg_hyplen = 16'd0;
    if (reg_hypaddress == ADDR_CFG)  reg_hyplen = 16'd5;
    if (reg_hypaddress == ADDR_DATA) reg_hyplen = 16'd1;
  end

endmodule

// File: tb/tb_reg_target_uart_sniff.sv
// Randomised bench for reg_target_uart_sniff.
// Checks the DUT against a transaction-level model.
module tb_reg_target_uart_sniff;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [5:0]  reg_address;
  logic [15:0] reg_bytecnt;
  logic [7:0]  reg_datai;
  logic [7:0]  reg_datao;
  logic [15:0] reg_size;
  logic        reg_read;
  logic        reg_write;
  logic        reg_addrvalid;
  logic [5:0]  reg_hypaddress;
  logic [15:0] reg_hyplen;
  logic        rx_io1_i;
  logic        rx_io2_i;
  logic        data_avail_o;

  reg_target_uart_sniff dut (
    .clk            (clk),
    .reset_i        (reset_i),
    .reg_address    (reg_address),
    .reg_bytecnt    (reg_bytecnt),
    .reg_datai      (reg_datai),
    .reg_datao      (reg_datao),
    .reg_size       (reg_size),
    .reg_read       (reg_read),
    .reg_write      (reg_write),
    .reg_addrvalid  (reg_addrvalid),
    .reg_hypaddress (reg_hypaddress),
    .reg_hyplen     (reg_hyplen),
    .rx_io1_i       (rx_io1_i),
    .rx_io2_i       (rx_io2_i),
    .data_avail_o   (data_avail_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit quiet = 1'b0;
  int hyp_fixed = -1;

  logic [7:0]  q[$];
  bit          m_en;
  bit          m_src;
  bit          m_pe;
  bit          m_po;
  logic [15:0] m_div;
  bit          m_ovf;
  bit          m_fe;
  bit          m_perr;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_en = 0; m_src = 0; m_pe = 0; m_po = 0;
    m_div = 16'd833;
    m_ovf = 0; m_fe = 0; m_perr = 0;
  endfunction

  function automatic logic [7:0] exp_cfg(input int idx);
    logic [7:0] r;
    int n;
    n = q.size();
    case (idx)
      0: r = {3'b000, m_po, m_pe, m_src, 1'b0, m_en};
      1: r = m_div[7:0];
      2: r = m_div[15:8];
      3: r = {3'b000, m_perr, m_fe, m_ovf, n == 64, n == 0};
      4: r = (n > 255) ? 8'hFF : 8'(n);
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [15:0] exp_hyp(input logic [5:0] a);
    if (a == 6'd56) return 16'd5;
    if (a == 6'd57) return 16'd1;
    return 16'd0;
  endfunction

  function automatic logic [5:0] other_addr();
    return 6'($urandom_range(0, 55));
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    forever begin
      @(negedge clk);
      if (hyp_fixed >= 0)
        reg_hypaddress = 6'(hyp_fixed);
      else if ($urandom_range(0, 3) == 0)
        reg_hypaddress = 6'(56 + $urandom_range(0, 1));
      else
        reg_hypaddress = 6'($urandom_range(0, 63));
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #3;
      chk("hyplen", reg_hyplen, exp_hyp(reg_hypaddress));
      if (reg_address != 6'd56 && reg_address != 6'd57)
        chk("datao_idle", reg_datao, 0);
      if (quiet)
        chk("data_avail", data_avail_o, q.size() != 0);
    end
  end

  task automatic settle();
    repeat (4) @(negedge clk);
    quiet = 1'b1;
  endtask

  task automatic wr_cfg(input int idx, input logic [7:0] d);
    quiet = 1'b0;
    @(negedge clk);
    reg_address   = 6'd56;
    reg_bytecnt   = 16'(idx);
    reg_datai     = d;
    reg_write     = 1'b1;
    reg_addrvalid = 1'b1;
    @(negedge clk);
    reg_write     = 1'b0;
    reg_addrvalid = 1'b0;
    reg_address   = other_addr();
    case (idx)
      0: begin
        m_en = d[0]; m_src = d[2]; m_pe = d[3]; m_po = d[4];
        if (d[1]) begin
          q.delete();
          m_ovf = 0; m_fe = 0; m_perr = 0;
        end
      end
      1: m_div[7:0]  = d;
      2: m_div[15:8] = d;
      default: ;
    endcase
  endtask

  task automatic rd_chk(input int idx, input string name, input int lit);
    @(negedge clk);
    reg_address = 6'd56;
    reg_bytecnt = 16'(idx);
    #2;
    chk(name, reg_datao, exp_cfg(idx));
    if (lit >= 0) chk({name, "_lit"}, reg_datao, lit);
    reg_address = other_addr();
  endtask

  task automatic pop_chk(input string name, input int lit);
    logic [7:0] e;
    quiet = 1'b0;
    e = (q.size() != 0) ? q[0] : 8'h00;
    @(negedge clk);
    reg_address   = 6'd57;
    reg_read      = 1'b1;
    reg_addrvalid = 1'b1;
    #2;
    chk(name, reg_datao, e);
    if (lit >= 0) chk({name, "_lit"}, reg_datao, lit);
    @(negedge clk);
    reg_read      = 1'b0;
    reg_addrvalid = 1'b0;
    reg_address   = other_addr();
    if (q.size() != 0) void'(q.pop_front());
  endtask

  task automatic send_byte(input logic [7:0] d, input bit bad_par,
                           input bit bad_stop);
    logic [10:0] bits;
    int n;
    int dv;
    bit sel;
    bit pe;
    quiet = 1'b0;
    dv  = int'(m_div);
    sel = m_src;
    pe  = m_pe;
    bits = '0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    n = 9;
    if (pe) begin
      bits[9] = (^d) ^ m_po ^ bad_par;
      n = 10;
    end
    bits[n] = ~bad_stop;
    n++;
    for (int b = 0; b < n; b++) begin
      repeat (dv) begin
        @(negedge clk);
        if (sel) begin
          rx_io2_i = bits[b];
          rx_io1_i = 1'($urandom_range(0, 1));
        end else begin
          rx_io1_i = bits[b];
          rx_io2_i = 1'($urandom_range(0, 1));
        end
      end
    end
    @(negedge clk);
    rx_io1_i = 1'b1;
    rx_io2_i = 1'b1;
    repeat (3) @(negedge clk);
    if (m_en) begin
      if (pe && bad_par) m_perr = 1;
      if (bad_stop) m_fe = 1;
      else if (q.size() == 64) m_ovf = 1;
      else q.push_back(d);
    end
  endtask

  initial begin
    logic [7:0] b1;
    reset_i       = 1'b1;
    reg_address   = 6'd0;
    reg_bytecnt   = 16'd0;
    reg_datai     = 8'd0;
    reg_size      = 16'd0;
    reg_read      = 1'b0;
    reg_write     = 1'b0;
    reg_addrvalid = 1'b0;
    rx_io1_i      = 1'b1;
    rx_io2_i      = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    #3;
    chk("rst_avail", data_avail_o, 0);
    chk("rst_datao", reg_datao, 0);
    reset_i = 1'b0;

    rd_chk(0, "rst_cfg0", 8'h00);
    rd_chk(1, "rst_cfg1", 8'h41);
    rd_chk(2, "rst_cfg2", 8'h03);
    rd_chk(3, "rst_cfg3", 8'h01);
    rd_chk(4, "rst_cfg4", 8'h00);
    rd_chk(5, "rst_cfg5", 8'h00);
    hyp_fixed = 56;
    @(negedge clk); #3;
    chk("hyp_cfg_lit", reg_hyplen, 16'd5);
    hyp_fixed = 57;
    @(negedge clk); #3;
    chk("hyp_data_lit", reg_hyplen, 16'd1);
    hyp_fixed = 0;
    @(negedge clk); #3;
    chk("hyp_zero_lit", reg_hyplen, 16'd0);
    hyp_fixed = -1;
    settle();

    wr_cfg(1, 8'd16);
    wr_cfg(2, 8'd0);
    wr_cfg(0, 8'h01);
    wr_cfg(3, 8'hFF);
    wr_cfg(4, 8'hFF);
    wr_cfg(7, 8'hFF);
    settle();
    rd_chk(0, "cfg0_en", 8'h01);
    rd_chk(3, "ro_ignored", 8'h01);
    send_byte(8'hA5, 0, 0);
    send_byte(8'h3C, 0, 0);
    settle();
    rd_chk(4, "cnt_two", 2);
    pop_chk("pop_a5", 8'hA5);
    pop_chk("pop_3c", 8'h3C);
    settle();
    rd_chk(3, "empty_after", 8'h01);
    chk("avail_low_lit", data_avail_o, 0);
    pop_chk("pop_empty", 8'h00);
    settle();
    rd_chk(4, "cnt_after_empty_pop", 0);

    wr_cfg(0, 8'h09);
    send_byte(8'h07, 1, 0);
    settle();
    rd_chk(3, "par_status", 8'h10);
    rd_chk(4, "par_cnt", 1);
    wr_cfg(0, 8'h0B);
    settle();
    rd_chk(3, "clr_status", 8'h01);
    wr_cfg(0, 8'h19);
    send_byte(8'($urandom), 0, 0);
    settle();
    rd_chk(3, "odd_ok_status", 8'h00);
    pop_chk("odd_pop", -1);

    wr_cfg(0, 8'h01);
    send_byte(8'h55, 0, 1);
    settle();
    rd_chk(3, "frame_status", 8'h09);
    rd_chk(4, "frame_cnt", 0);
    quiet = 1'b0;
    @(negedge clk); rx_io1_i = 1'b0;
    @(negedge clk); rx_io1_i = 1'b1;
    repeat (40) @(negedge clk);
    settle();
    rd_chk(4, "glitch_cnt", 0);
    rd_chk(3, "glitch_status", 8'h09);
    send_byte(8'h81, 0, 0);
    settle();
    pop_chk("after_glitch", 8'h81);

    wr_cfg(0, 8'h07);
    for (int i = 0; i < 65; i++) begin
      send_byte(8'($urandom), 0, 0);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    settle();
    b1 = q[0];
    rd_chk(4, "ovf_cnt", 64);
    rd_chk(3, "ovf_status", 8'h06);
    pop_chk("ovf_first", int'(b1));
    for (int i = 0; i < 63; i++) pop_chk("ovf_drain", -1);
    settle();
    rd_chk(3, "drained_status", 8'h05);

    for (int off = -2; off <= 2; off++) begin
      wr_cfg(0, 8'h03);
      for (int i = 0; i < 3; i++) send_byte(8'($urandom), 0, 0);
      settle();
      rd_chk(4, "pp_pre", 3);
      fork
        send_byte(8'($urandom), 0, 0);
        begin
          repeat (155 + off) @(negedge clk);
          pop_chk("pp_pop", -1);
        end
      join
      settle();
      rd_chk(4, "pp_cnt", 3);
      for (int i = 0; i < 3; i++) pop_chk("pp_drain", -1);
    end

    wr_cfg(0, 8'h03);
    send_byte(8'h5A, 0, 0);
    settle();
    rd_chk(4, "pre_rst_cnt", 1);
    fork
      send_byte(8'hC3, 0, 0);
      begin
        repeat (60) @(negedge clk);
        quiet = 1'b0;
        reset_i = 1'b1;
        model_reset();
        @(negedge clk); #1;
        chk("mid_rst_avail", data_avail_o, 0);
        rd_chk(0, "mid_rst_cfg0", 8'h00);
        rd_chk(1, "mid_rst_cfg1", 8'h41);
        rd_chk(3, "mid_rst_cfg3", 8'h01);
        rd_chk(4, "mid_rst_cfg4", 8'h00);
        pop_chk("mid_rst_data", 8'h00);
        reset_i = 1'b0;
      end
    join
    settle();
    rd_chk(4, "post_rst_cnt", 0);
    rd_chk(2, "post_rst_cfg2", 8'h03);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
